// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
//   arb_state_e : arbiter FSM state (IDLE -> GRANT -> GAP -> IDLE)
//   N_REQ       : number of requesters
//   IDX_W       : width of an encoded requester index
package rr_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb_8_enc.sv
// ENC_8_3: 8-to-3 one-hot encoder.
//   dat_in  : one-hot input vector
//   dat_out : index of the set bit (OR of indices of all set bits when not one-hot)
//   err     : 1 when dat_in is not exactly one-hot (zero or multiple bits set)
module ENC_8_3
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] dat_in,
  output logic [IDX_W-1:0] dat_out,
  output logic             err
);

  logic [IDX_W:0] ones;

  always_comb begin
    dat_out = '0;
    ones    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (dat_in[i]) begin
        dat_out = dat_out | IDX_W'(i);
      end
      ones = ones + (IDX_W + 1)'(dat_in[i]);
    end
    err = (ones != (IDX_W + 1)'(1));
  end

endmodule

// File: rtl/rr_arb_8.sv
// rr_arb_8: round-robin arbiter sharing one resource among 8 requesters.
//   clk     : clock, all state updates on posedge
//   rst_n   : asynchronous active-low reset
//   req     : level-sensitive request vector, bit i = requester i
//   done    : owner releases the resource (sampled only in GRANT)
//   gnt     : registered one-hot grant, zero when no owner
//   gnt_idx : encoded index of gnt, 0 when gnt_vld = 0
//   gnt_vld : 1 while in GRANT
//   timeout : one-cycle pulse in the first GAP cycle after a forced release
//   err     : encoder error gated by gnt_vld (non-one-hot grant)
module rr_arb_8
  import rr_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout,
  output logic             err
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(HOLD_MAX - 1);

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] ptr_q;
  logic             timeout_q;

  logic [IDX_W-1:0] sel;
  logic             owner_req;
  logic             at_limit;
  logic             release_now;
  logic [IDX_W-1:0] gnt_idx_raw;
  logic             enc_err;

  // Rotate so requester ptr+1 lands at bit 0, take the lowest set bit, rotate the
  // index back. Requester ptr therefore ends up with the lowest priority.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic               found;
    logic [IDX_W-1:0]   pick;
    dbl   = {r, r} >> ((IDX_W + 1)'(p) + (IDX_W + 1)'(1));
    rot   = dbl[N_REQ-1:0];
    found = 1'b0;
    pick  = p;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        pick  = p + IDX_W'(1) + IDX_W'(j);
      end
    end
    return pick;
  endfunction

  always_comb begin
    sel         = rr_pick(req, ptr_q);
    owner_req   = |(req & gnt_q);
    at_limit    = (cnt_q == CntLast);
    release_now = done || !owner_req || at_limit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      cnt_q     <= '0;
      ptr_q     <= IDX_W'(N_REQ - 1);
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q   <= N_REQ'(1) << sel;
            cnt_q   <= '0;
            ptr_q   <= sel;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            gnt_q     <= '0;
            state_q   <= GAP;
            // Only a release caused purely by the hold limit counts as a timeout.
            timeout_q <= at_limit && !done && owner_req;
          end
          if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  ENC_8_3 u_enc (
    .dat_in  (gnt_q),
    .dat_out (gnt_idx_raw),
    .err     (enc_err)
  );

  always_comb begin
    gnt     = gnt_q;
    gnt_vld = (state_q == GRANT);
    gnt_idx = gnt_vld ? gnt_idx_raw : '0;
    err     = enc_err && gnt_vld;
    timeout = timeout_q;
  end

endmodule

// File: tb/tb_rr_arb_8.sv
// Directed bench for rr_arb_8 with HOLD_MAX = 15. Inputs change and outputs are
// sampled on the falling edge.
module tb_rr_arb_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;
  logic       err;

  int n_vec;
  int n_err;

  rr_arb_8 #(
    .HOLD_MAX (15),
    .CNT_W    (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Wait (bounded) for a grant to appear; an expired bound shows up as a failed check.
  task automatic wait_vld(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (gnt_vld) break;
      step();
    end
    chk(tag, {7'd0, gnt_vld}, 8'h01);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, gnt, 8'h00);
    chk({tag, "_vld"}, {7'd0, gnt_vld}, 8'h00);
    chk({tag, "_idx"}, {5'd0, gnt_idx}, 8'h00);
    chk({tag, "_err"}, {7'd0, err}, 8'h00);
  endtask

  initial begin
    int held;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;

    // Reset state and ten idle cycles with no requests.
    step();
    chk_idle("reset");
    chk("reset_to", {7'd0, timeout}, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_idle("idle10");
    end

    // req = 81: requester 0 first, then 7 after done, GAP and IDLE.
    req = 8'h81;
    step();
    chk("t2_gnt0", gnt, 8'h01);
    chk("t2_idx0", {5'd0, gnt_idx}, 8'h00);
    chk("t2_vld0", {7'd0, gnt_vld}, 8'h01);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t2_gap", gnt, 8'h00);
    chk("t2_gap_to", {7'd0, timeout}, 8'h00);
    step();
    chk("t2_idle", gnt, 8'h00);
    step();
    chk("t2_gnt7", gnt, 8'h80);
    chk("t2_idx7", {5'd0, gnt_idx}, 8'h07);
    // Owner dropping its request also releases.
    req = 8'h00;
    step();
    chk("t2_drop", gnt, 8'h00);
    step();
    step();
    chk_idle("t2_end");

    // All request, done on the third grant cycle: owners rotate 0..7,0.
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] exp_g;
      exp_g = 8'h01 << (k % 8);
      wait_vld("rot_wait");
      chk("rot_gnt", gnt, exp_g);
      chk("rot_idx", {5'd0, gnt_idx}, 8'(k % 8));
      chk("rot_err", {7'd0, err}, 8'h00);
      step();
      step();
      chk("rot_hold3", gnt, exp_g);
      done = 1'b1;
      step();
      done = 1'b0;
      chk("rot_gap", gnt, 8'h00);
    end
    req = 8'h00;
    step();
    step();
    chk_idle("rot_end");

    // Single requester, no done: forced release after exactly 15 grant cycles.
    req = 8'h10;
    step();
    chk("to_gnt", gnt, 8'h10);
    held = 0;
    for (int i = 0; i < 40; i++) begin
      if (!gnt_vld) break;
      if (gnt == 8'h10) held++;
      chk("to_nopulse", {7'd0, timeout}, 8'h00);
      step();
    end
    chk("to_held", 8'(held), 8'd15);
    chk("to_pulse", {7'd0, timeout}, 8'h01);
    chk("to_gap_gnt", gnt, 8'h00);
    step();
    chk("to_pulse_end", {7'd0, timeout}, 8'h00);
    chk("to_idle_gnt", gnt, 8'h00);
    step();
    chk("to_regnt", gnt, 8'h10);
    chk("to_regnt_idx", {5'd0, gnt_idx}, 8'h04);

    // done in the same cycle as the hold limit: normal release, no timeout.
    for (int i = 0; i < 14; i++) step();
    chk("dl_last_cycle", {7'd0, gnt_vld}, 8'h01);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("dl_gnt", gnt, 8'h00);
    chk("dl_timeout", {7'd0, timeout}, 8'h00);

    // Grant to 2, then async reset mid-grant; ptr must return to 7.
    req = 8'h04;
    wait_vld("rst_wait");
    chk("rst_pre", gnt, 8'h04);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_gnt", gnt, 8'h00);
    chk("rst_async_vld", {7'd0, gnt_vld}, 8'h00);
    step();
    rst_n = 1'b1;
    req   = 8'h0C;
    step();
    chk("rst_ptr", gnt, 8'h04);
    chk("rst_ptr_idx", {5'd0, gnt_idx}, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
